// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter
// Round-robin arbiter sharing one single-byte SPI master among NUM_REQ
// requesters. Each grant drives one active-low chip-select, launches the
// master with the latched byte, waits for completion, returns the received
// byte and acks the requester. A CS_GAP-cycle deselect gap follows every
// transaction.
//
// Optional build macro: SPI_ARB_TIMEOUT_EN
//   Adds a WAIT watchdog. After TIMEOUT cycles in WAIT without m_done, the
//   transaction is closed with rx_data = 8'hFF and err_timeout pulses with
//   req_ack. Without the macro, WAIT lasts until m_done and err_timeout is 0.

module spi_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int CS_GAP  = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*8-1:0]       req_data,
   output logic [NUM_REQ-1:0]         req_ack,
   output logic [7:0]                 rx_data,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       m_start,
   output logic [7:0]                 m_tx_data,
   output logic [NUM_REQ-1:0]         m_cs_n,
   input  logic                       m_done,
   input  logic [7:0]                 m_rx_data,
   output logic                       err_timeout
);

   // state   | meaning
   // --------+------------------------------------------------------------
   // IDLE    | no transaction; arbitrate among pending requests
   // START   | one-cycle m_start pulse, granted chip-select low
   // WAIT    | chip-select held low until the master reports completion
   // RELEASE | all chip-selects high for CS_GAP cycles; ack on first cycle

   localparam int IDW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_START   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   localparam logic [3:0] GAP_LOAD = 4'(CS_GAP - 1);

   generate
      if (NUM_REQ < 2 || NUM_REQ > 8 || CS_GAP < 1 || CS_GAP > 15 || TIMEOUT < 1) begin : g_bad_param
         $error("spi_req_arbiter: parameter out of range");
      end
   endgenerate

   state_t           state_q;
   state_t           state_d;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   pick_id;
   logic [IDW-1:0]   cand;
   logic             any_req;
   logic [3:0]       gap_cnt;
   logic             gap_first;
   logic             gap_last;
   logic             to_hit;

   assign gap_first = (gap_cnt == GAP_LOAD);
   assign gap_last  = (gap_cnt == 4'd0);

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT - 1);

   logic [TW-1:0] to_cnt;
   logic          to_flag;

   // Watchdog fires on the terminal-count WAIT cycle unless m_done wins.
   assign to_hit      = (state_q == ST_WAIT) && !m_done && (to_cnt == '0);
   assign err_timeout = (state_q == ST_RELEASE) && gap_first && to_flag;

   // WAIT watchdog: down-counter loaded in START, terminal count at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt  <= '0;
         to_flag <= 1'b0;
      end else if (state_q == ST_START) begin
         to_cnt  <= TO_LOAD;
         to_flag <= 1'b0;
      end else if (state_q == ST_WAIT) begin
         if (to_hit) begin
            to_flag <= 1'b1;
         end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - TW'(1);
         end
      end
   end
`else
   assign to_hit      = 1'b0;
   assign err_timeout = 1'b0;
`endif

   // Round-robin pick: first set request scanning upward from rr_ptr.
   always_comb begin
      any_req = 1'b0;
      pick_id = rr_ptr;
      cand    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IDW'((int'(rr_ptr) + i) % NUM_REQ);
         if (!any_req && req[cand]) begin
            any_req = 1'b1;
            pick_id = cand;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and decoded outputs.
   always_comb begin
      state_d = state_q;
      m_start = 1'b0;
      m_cs_n  = '1;
      req_ack = '0;
      busy    = 1'b1;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (any_req) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            m_start          = 1'b1;
            m_cs_n[grant_id] = 1'b0;
            state_d          = ST_WAIT;
         end
         ST_WAIT: begin
            m_cs_n[grant_id] = 1'b0;
            if (m_done || to_hit) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (gap_first) begin
               req_ack[grant_id] = 1'b1;
            end
            if (gap_last) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Grant/data capture, deselect-gap down-counter and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr    <= '0;
         grant_id  <= '0;
         m_tx_data <= 8'h00;
         rx_data   <= 8'h00;
         gap_cnt   <= 4'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_req) begin
                  grant_id  <= pick_id;
                  m_tx_data <= req_data[{pick_id, 3'b000} +: 8];
               end
            end
            ST_WAIT: begin
               if (m_done) begin
                  rx_data <= m_rx_data;
                  gap_cnt <= GAP_LOAD;
               end else if (to_hit) begin
                  rx_data <= 8'hFF;
                  gap_cnt <= GAP_LOAD;
               end
            end
            ST_RELEASE: begin
               if (gap_last) begin
                  rr_ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter (NUM_REQ=4, CS_GAP=2, TIMEOUT=64).
// Timeout scenario is included when built with SPI_ARB_TIMEOUT_EN.

module tb_spi_req_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_ack;
   logic [7:0]  rx_data;
   logic        busy;
   logic [1:0]  grant_id;
   logic        m_start;
   logic [7:0]  m_tx_data;
   logic [3:0]  m_cs_n;
   logic        m_done;
   logic [7:0]  m_rx_data;
   logic        err_timeout;

   int checks     = 0;
   int failures   = 0;
   int cs_viol    = 0;
   int start_viol = 0;
   int start_cnt  = 0;
   int exp_starts = 0;
   logic prev_busy = 1'b0;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic [7:0]  rx;
      int          dly;
      logic [1:0]  gnt;
      logic [7:0]  tx;
      logic [3:0]  drop;
      int          lat;
      bit          rel_pulse;
   } vec_t;

   vec_t vecs[9];
   vec_t vx;

   spi_req_arbiter #(
      .NUM_REQ (4),
      .CS_GAP  (2),
      .TIMEOUT (64)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .req_ack     (req_ack),
      .rx_data     (rx_data),
      .busy        (busy),
      .grant_id    (grant_id),
      .m_start     (m_start),
      .m_tx_data   (m_tx_data),
      .m_cs_n      (m_cs_n),
      .m_done      (m_done),
      .m_rx_data   (m_rx_data),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst) begin
         prev_busy = 1'b0;
      end else begin
         if ($countones(~m_cs_n) > 1) cs_viol++;
         if (m_start) begin
            start_cnt++;
            if (prev_busy) start_viol++;
         end
         prev_busy = busy;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_start(output int lat);
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (m_start === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic do_txn(input vec_t v, input string tag);
      int         lat;
      logic       hold_ok;
      logic [3:0] exp_cs;
      exp_cs   = ~(4'b0001 << v.gnt);
      req      = v.req;
      req_data = v.data;
      exp_starts++;
      wait_start(lat);
      chk({tag, " start_latency"}, lat, v.lat);
      if (lat == 0) return;
      chk({tag, " grant_id"}, grant_id, v.gnt);
      chk({tag, " m_tx_data"}, m_tx_data, v.tx);
      chk({tag, " cs_at_start"}, m_cs_n, exp_cs);
      hold_ok = 1'b1;
      for (int k = 1; k <= v.dly; k++) begin
         @(negedge clk);
         if (m_cs_n !== exp_cs || m_start !== 1'b0 || busy !== 1'b1 ||
             req_ack !== 4'b0 || m_tx_data !== v.tx) hold_ok = 1'b0;
         if (k == v.dly) begin
            m_done    = 1'b1;
            m_rx_data = v.rx;
         end
      end
      chk({tag, " wait_hold"}, hold_ok, 1'b1);
      @(negedge clk);
      m_done = 1'b0;
      chk({tag, " req_ack"}, req_ack, 4'b0001 << v.gnt);
      chk({tag, " rx_data"}, rx_data, v.rx);
      chk({tag, " cs_gap1"}, m_cs_n, 4'b1111);
      chk({tag, " err_timeout"}, err_timeout, 1'b0);
      req = req & ~v.drop;
      if (v.rel_pulse) begin
         m_done    = 1'b1;
         m_rx_data = 8'hEE;
      end
      @(negedge clk);
      m_done = 1'b0;
      chk({tag, " ack_once"}, req_ack, 4'b0000);
      chk({tag, " cs_gap2"}, m_cs_n, 4'b1111);
      chk({tag, " rx_hold"}, rx_data, v.rx);
      chk({tag, " busy_gap"}, busy, 1'b1);
   endtask

   initial begin
      int   lat;
      logic ok;

      rst       = 1'b1;
      req       = 4'b0;
      req_data  = 32'h0;
      m_done    = 1'b0;
      m_rx_data = 8'h00;

      //            req      data          rx     dly gnt tx     drop     lat rel
      vecs[0] = '{4'b0001, 32'h000000A5, 8'h3C, 20, 2'd0, 8'hA5, 4'b0001, 1, 1'b0};
      vecs[1] = '{4'b0110, 32'h00221100, 8'h5A,  3, 2'd1, 8'h11, 4'b0010, 2, 1'b1};
      vecs[2] = '{4'b0100, 32'h00221100, 8'h7E,  5, 2'd2, 8'h22, 4'b0100, 2, 1'b0};
      vecs[3] = '{4'b1111, 32'hD4C3B2A1, 8'h01,  1, 2'd0, 8'hA1, 4'b0000, 1, 1'b0};
      vecs[4] = '{4'b1111, 32'hD4C3B2A1, 8'h02,  2, 2'd1, 8'hB2, 4'b0000, 2, 1'b0};
      vecs[5] = '{4'b1111, 32'hD4C3B2A1, 8'h03,  4, 2'd2, 8'hC3, 4'b0000, 2, 1'b0};
      vecs[6] = '{4'b1111, 32'hD4C3B2A1, 8'h04,  1, 2'd3, 8'hD4, 4'b0000, 2, 1'b0};
      vecs[7] = '{4'b1111, 32'hD4C3B2A1, 8'h05,  7, 2'd0, 8'hA1, 4'b0000, 2, 1'b0};
      vecs[8] = '{4'b1111, 32'hD4C3B2A1, 8'h06,  2, 2'd1, 8'hB2, 4'b1111, 2, 1'b0};

      repeat (3) @(negedge clk);
      chk("reset m_cs_n", m_cs_n, 4'b1111);
      chk("reset busy", busy, 1'b0);
      chk("reset req_ack", req_ack, 4'b0);
      chk("reset m_start", m_start, 1'b0);
      chk("reset rx_data", rx_data, 8'h00);
      chk("reset m_tx_data", m_tx_data, 8'h00);
      chk("reset grant_id", grant_id, 2'd0);
      chk("reset err_timeout", err_timeout, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

      // m_done while IDLE must be ignored
      @(negedge clk);
      m_done    = 1'b1;
      m_rx_data = 8'h99;
      @(negedge clk);
      m_done = 1'b0;
      chk("idle_done busy", busy, 1'b0);
      chk("idle_done req_ack", req_ack, 4'b0);
      chk("idle_done rx_data", rx_data, 8'h7E);
      @(negedge clk);
      chk("idle_done no_start", m_start, 1'b0);
      chk("idle_done busy2", busy, 1'b0);

      // reset in IDLE returns the round-robin pointer to 0
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 3; i < 9; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

      // reset during WAIT aborts without ack
      req      = 4'b1111;
      req_data = 32'hD4C3B2A1;
      exp_starts++;
      wait_start(lat);
      chk("abort start_latency", lat, 2);
      chk("abort grant_id", grant_id, 2'd2);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort m_cs_n", m_cs_n, 4'b1111);
      chk("abort busy", busy, 1'b0);
      chk("abort req_ack", req_ack, 4'b0);
      chk("abort rx_data", rx_data, 8'h00);
      rst = 1'b0;
      vx = '{4'b1111, 32'hD4C3B2A1, 8'h77, 2, 2'd0, 8'hA1, 4'b1111, 1, 1'b0};
      do_txn(vx, "post_abort");

`ifdef SPI_ARB_TIMEOUT_EN
      req      = 4'b0010;
      req_data = 32'h00005C00;
      exp_starts++;
      wait_start(lat);
      chk("to start_latency", lat, 2);
      chk("to grant_id", grant_id, 2'd1);
      chk("to m_tx_data", m_tx_data, 8'h5C);
      ok = 1'b1;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (req_ack !== 4'b0 || err_timeout !== 1'b0 || m_cs_n !== 4'b1101) ok = 1'b0;
      end
      chk("to wait_hold", ok, 1'b1);
      @(negedge clk);
      chk("to req_ack", req_ack, 4'b0010);
      chk("to err_timeout", err_timeout, 1'b1);
      chk("to rx_data", rx_data, 8'hFF);
      chk("to cs_gap", m_cs_n, 4'b1111);
      req = 4'b0;
      @(negedge clk);
      chk("to err_once", err_timeout, 1'b0);
      chk("to ack_once", req_ack, 4'b0);
      vx = '{4'b0100, 32'h00330000, 8'h42, 4, 2'd2, 8'h33, 4'b0100, 2, 1'b0};
      do_txn(vx, "after_to");
`endif

      repeat (3) @(negedge clk);
      chk("cs_onehot violations", cs_viol, 0);
      chk("start_while_busy violations", start_viol, 0);
      chk("m_start pulse count", start_cnt, exp_starts);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Round-robin arbiter that shares one single-byte SPI master engine among NUM_REQ requesters.
- Per transaction: selects a requester, drives that requester's one-hot chip-select, launches the master with the latched byte, waits for master completion, returns the received byte and acknowledges.
- Sits between client logic and the SPI master/slave datapath; all timing is in the system clock domain.

Parameters:
- NUM_REQ, 4, number of requesters and chip-selects; legal range 2..8.
- CS_GAP, 2, idle cycles with all chip-selects deasserted after each transaction; legal range 1..15.
- TIMEOUT, 64, cycles allowed in WAIT before abort; used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester transaction request, level; held until ack.
- req_data  in  NUM_REQ*8  byte to send; requester i uses bits [8i+7:8i].
- req_ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rx_data  out  8  byte received in the last completed transaction.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- m_start  out  1  one-cycle launch pulse to the SPI master.
- m_tx_data  out  8  byte to the master; stable from START until leaving WAIT.
- m_cs_n  out  NUM_REQ  active-low chip-selects; at most one low.
- m_done  in  1  master completion pulse.
- m_rx_data  in  8  master receive byte; valid when m_done=1.
- err_timeout  out  1  timeout pulse; tied 0 without SPI_ARB_TIMEOUT_EN.

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0.
  - m_cs_n all ones; m_start, req_ack, err_timeout = 0.
  - rx_data=0, m_tx_data=0, busy=0.
  - Reset during any state aborts immediately; no ack is issued for the aborted transaction.
- States: IDLE, START, WAIT, RELEASE.
- IDLE:
  - If any req bit is set, choose the first set bit scanning upward from rr_ptr, wrapping at NUM_REQ-1 -> 0.
  - Register grant_id, latch m_tx_data from req_data, go to START.
  - If no req bit is set, stay in IDLE.
- START: exactly one cycle. m_start=1; m_cs_n[grant_id]=0. Go to WAIT.
- WAIT:
  - m_cs_n[grant_id] is held low.
  - On m_done=1: register rx_data <= m_rx_data, then go to RELEASE.
- RELEASE:
  - First cycle: req_ack[grant_id]=1; rx_data is valid.
  - All m_cs_n are high for exactly CS_GAP cycles, then go to IDLE.
  - On exit, rr_ptr = (grant_id+1) mod NUM_REQ.
- Latency: req high at IDLE edge k -> m_start and cs low in cycle k+1. m_done at edge j -> req_ack in cycle j+1.
- Minimum back-to-back spacing: 1 (START) + WAIT length + CS_GAP + 1 (IDLE) cycles.
- req deasserted after grant: ignored. The transaction completes and req_ack still pulses.
- m_done outside WAIT: ignored; no state change.
- req_data changes after latching: no effect on the current transaction.
- rx_data holds its value until the next completed transaction.
- grant_id holds after RELEASE until the next grant.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 with m_done=0, go to RELEASE with rx_data=8'hFF.
  - err_timeout=1 in the same cycle as req_ack.
  - If m_done=1 on the terminal count cycle, the transfer completes normally with no error.
- Undefined: no counter exists; WAIT persists until m_done; err_timeout is constant 0.

Test Plan:
- req=4'b0001, req_data[7:0]=8'hA5, m_done 20 cycles after m_start with m_rx_data=8'h3C:
  - m_tx_data=8'hA5, m_cs_n=4'b1110, one m_start pulse.
  - req_ack=4'b0001 with rx_data=8'h3C.
  - m_cs_n=4'b1111 for 2 cycles.
- req=4'b0110 asserted together, each dropped after its ack: grants in order 1 then 2; never two chip-selects low at once.
- req=4'b1111 held continuously for 6 transactions: grant_id sequence 0,1,2,3,0,1; no m_start while busy.
- rst asserted during WAIT:
  - Next cycle m_cs_n=4'b1111, busy=0, req_ack=0, rx_data=0.
  - Next grant with req=4'b1111 goes to requester 0.
- m_done pulsed during IDLE and RELEASE: no state change, no ack; rx_data unchanged.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT=64, m_done never asserted:
  - req_ack and err_timeout pulse 64 cycles after WAIT entry, rx_data=8'hFF.
  - The next requester is then served normally.
